// File: rtl/op_ras_pkg.sv
// Shared constants and FSM state encoding for the return-address stack.
// The link increment matches the link unit so pushed addresses agree with LR.
package op_ras_pkg;

  localparam int          RAS_DEPTH_DEFAULT = 8;
  localparam logic [31:0] LINK_INC          = 32'd1;

  typedef enum logic {
    RAS_IDLE = 1'b0,
    RAS_RESP = 1'b1
  } ras_state_e;

endpackage

// File: rtl/op_ras_mem.sv
// DEPTH x AW register file with one write port and one combinational read port, no reset.
// Write takes effect on the next edge; the read port shows the current contents.
module op_ras_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rdata
);

  logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/op_return_stack.sv
// Return-address stack: calls push call_pc+1, returns pop over valid/ready; OP_RAS_MISPREDICT_EN adds a mispredict counter.
// Pop response valid one cycle after ret_req; response held until ret_ready, ret_req ignored meanwhile; pushes never stall.
module op_return_stack
  import op_ras_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEFAULT,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     call_valid,
  input  logic [AW-1:0]            call_pc,
  input  logic                     ret_req,
  output logic                     ret_valid,
  input  logic                     ret_ready,
  output logic [AW-1:0]            ret_addr,
  output logic                     ret_miss,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
`ifdef OP_RAS_MISPREDICT_EN
  ,
  input  logic                     act_valid,
  input  logic [AW-1:0]            act_addr,
  output logic [15:0]              mispred_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ras_state_e    state;
  logic [PW-1:0] tos;
  logic [PW-1:0] wr_ptr;
  logic [AW-1:0] top_dat;
  logic [AW-1:0] link_addr;
  logic          push_go;
  logic          pop_go;
  logic          pop_hit;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign push_go   = call_valid && !flush;
  assign pop_go    = (state == RAS_IDLE) && ret_req && !flush;
  assign pop_hit   = pop_go && !empty;
  assign link_addr = call_pc + AW'(LINK_INC);
  // A push alongside a successful pop replaces the entry being popped.
  assign wr_ptr    = pop_hit ? tos : tos + PW'(1);

  op_ras_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_go),
    .waddr (wr_ptr),
    .wdata (link_addr),
    .raddr (tos),
    .rdata (top_dat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RAS_IDLE;
      tos       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      ret_valid <= 1'b0;
      ret_addr  <= '0;
      ret_miss  <= 1'b0;
    end else if (flush) begin
      state     <= RAS_IDLE;
      tos       <= '0;
      count     <= '0;
      ret_valid <= 1'b0;
    end else begin
      if (push_go && !pop_hit) begin
        tos <= tos + PW'(1);
        if (full) overflow <= 1'b1;
        else      count    <= count + CW'(1);
      end else if (pop_hit && !push_go) begin
        tos   <= tos - PW'(1);
        count <= count - CW'(1);
      end

      case (state)
        RAS_IDLE: begin
          if (ret_req) begin
            state     <= RAS_RESP;
            ret_valid <= 1'b1;
            ret_addr  <= pop_hit ? top_dat : '0;
            ret_miss  <= !pop_hit;
          end
        end
        RAS_RESP: begin
          if (ret_ready) begin
            state     <= RAS_IDLE;
            ret_valid <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef OP_RAS_MISPREDICT_EN
  logic [AW-1:0] last_addr;
  logic          last_miss;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispred_cnt <= '0;
      last_addr   <= '0;
      last_miss   <= 1'b0;
    end else begin
      if (ret_valid && ret_ready && !flush) begin
        last_addr <= ret_addr;
        last_miss <= ret_miss;
      end
      if (act_valid && (last_miss || (act_addr != last_addr)) && (mispred_cnt != 16'hFFFF))
        mispred_cnt <= mispred_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_op_return_stack.sv
// Directed and random stimulus for op_return_stack, checked against a queue-based stack model.
module tb_op_return_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          call_valid;
  logic [AW-1:0] call_pc;
  logic          ret_req;
  logic          ret_valid;
  logic          ret_ready;
  logic [AW-1:0] ret_addr;
  logic          ret_miss;
  logic          flush;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          act_valid;
  logic [AW-1:0] act_addr;
`ifdef OP_RAS_MISPREDICT_EN
  logic [15:0]   mispred_cnt;
`endif

  op_return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .call_valid (call_valid),
    .call_pc    (call_pc),
    .ret_req    (ret_req),
    .ret_valid  (ret_valid),
    .ret_ready  (ret_ready),
    .ret_addr   (ret_addr),
    .ret_miss   (ret_miss),
    .flush      (flush),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow)
`ifdef OP_RAS_MISPREDICT_EN
    ,
    .act_valid  (act_valid),
    .act_addr   (act_addr),
    .mispred_cnt(mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the stack is a queue whose back is the top.
  logic [AW-1:0] mq[$];
  bit            m_ovf;
  bit            m_resp;
  bit            m_miss;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_mis;
  logic [AW-1:0] m_last_addr;
  bit            m_last_miss;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [AW-1:0] tmp;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_resp = 0; m_miss = 0; m_addr = '0;
      m_mis = '0; m_last_addr = '0; m_last_miss = 0;
    end else begin
      if (act_valid && (m_last_miss || act_addr != m_last_addr) && m_mis != 16'hFFFF)
        m_mis = m_mis + 16'd1;
      if (flush) begin
        mq.delete();
        m_resp = 0;
      end else begin
        if (m_resp && ret_ready) begin
          m_last_addr = m_addr;
          m_last_miss = m_miss;
          m_resp = 0;
        end else if (!m_resp && ret_req) begin
          m_resp = 1;
          if (mq.size() > 0) begin
            m_addr = mq.pop_back();
            m_miss = 0;
          end else begin
            m_addr = '0;
            m_miss = 1;
          end
        end
        if (call_valid) begin
          tmp = call_pc + 32'd1;
          mq.push_back(tmp);
          if (mq.size() > DEPTH) begin
            void'(mq.pop_front());
            m_ovf = 1;
          end
        end
      end
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ":valid"}, ret_valid, m_resp);
    chk({tag, ":addr"},  ret_addr,  m_addr);
    chk({tag, ":miss"},  ret_miss,  m_miss);
    chk({tag, ":count"}, count,     mq.size());
    chk({tag, ":empty"}, empty,     mq.size() == 0);
    chk({tag, ":full"},  full,      mq.size() == DEPTH);
    chk({tag, ":ovf"},   overflow,  m_ovf);
`ifdef OP_RAS_MISPREDICT_EN
    chk({tag, ":mis"},   mispred_cnt, m_mis);
`endif
  endtask

  task automatic step(input bit cv, input logic [AW-1:0] pc, input bit rq, input bit rdy,
                      input bit fl, input bit rn, input string tag);
    call_valid = cv; call_pc = pc; ret_req = rq; ret_ready = rdy; flush = fl; rst_n = rn;
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  task automatic push(input logic [AW-1:0] pc);
    step(1, pc, 0, 0, 0, 1, "push");
  endtask

  task automatic pop_exp(input string tag, input logic [AW-1:0] addr, input bit miss);
    step(0, '0, 1, 0, 0, 1, {tag, "_req"});
    chk({tag, "_valid"}, ret_valid, 1);
    chk({tag, "_addr"},  ret_addr,  addr);
    chk({tag, "_miss"},  ret_miss,  miss);
    step(0, '0, 0, 1, 0, 1, {tag, "_acc"});
    chk({tag, "_done"},  ret_valid, 0);
  endtask

  initial begin
    call_valid = 0; call_pc = '0; ret_req = 0; ret_ready = 0;
    flush = 0; rst_n = 0; act_valid = 0; act_addr = '0;

    step(0, '0, 0, 0, 0, 0, "reset");
    step(0, '0, 0, 0, 0, 0, "reset");
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_valid", ret_valid, 0);

    // Basic LIFO order with link increment
    push(32'h100); push(32'h200); push(32'h300);
    chk("t1_count", count, 3);
    pop_exp("t1_p0", 32'h301, 0);
    pop_exp("t1_p1", 32'h201, 0);
    pop_exp("t1_p2", 32'h101, 0);
    chk("t1_count0", count, 0);
    chk("t1_empty", empty, 1);

    // Pop on empty stack
    pop_exp("t2", 32'h0, 1);
    chk("t2_count", count, 0);

    // Overflow wrap
    for (int i = 0; i < 9; i++) push(32'h10 + i);
    chk("t3_full", full, 1);
    chk("t3_ovf", overflow, 1);
    chk("t3_count", count, DEPTH);
    for (int i = 0; i < 8; i++) pop_exp("t3_pop", 32'h19 - i, 0);
    pop_exp("t3_miss", 32'h0, 1);

    // Backpressure: response held, pushes accepted, extra ret_req ignored
    push(32'h20);
    step(0, '0, 1, 0, 0, 1, "t4_req");
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h50 + i, 1, 0, 0, 1, "t4_hold");
      chk("t4_addr", ret_addr, 32'h21);
      chk("t4_cnt", count, i + 1);
    end
    step(0, '0, 0, 1, 0, 1, "t4_acc");
    step(0, '0, 0, 0, 1, 1, "t4_flush");
    chk("t4_flush_ovf", overflow, 1);

    // Simultaneous push and pop
    push(32'h20);
    step(1, 32'h40, 1, 0, 0, 1, "t5_both");
    chk("t5_addr", ret_addr, 32'h21);
    chk("t5_count", count, 1);
    step(0, '0, 0, 1, 0, 1, "t5_acc");
    pop_exp("t5_next", 32'h41, 0);

    // Flush and reset while a response is pending
    push(32'h30);
    step(0, '0, 1, 0, 0, 1, "t6_req");
    step(0, '0, 0, 0, 1, 1, "t6_flush");
    chk("t6_fl_valid", ret_valid, 0);
    chk("t6_fl_count", count, 0);
    push(32'h30);
    step(0, '0, 1, 0, 0, 1, "t6_req2");
    step(0, '0, 0, 0, 0, 0, "t6_rst");
    chk("t6_rst_valid", ret_valid, 0);
    chk("t6_rst_ovf", overflow, 0);
    step(0, '0, 0, 0, 0, 1, "t6_idle");

    // Resolved target differs from the prediction
    push(32'h20);
    pop_exp("t7", 32'h21, 0);
    act_valid = 1; act_addr = 32'h99;
    step(0, '0, 0, 0, 0, 1, "t7_act");
    act_valid = 0;
`ifdef OP_RAS_MISPREDICT_EN
    chk("t7_mis", mispred_cnt, 1);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      act_valid = ($urandom % 4) == 0;
      act_addr  = (($urandom % 2) == 0) ? m_last_addr : 32'($urandom);
      step($urandom % 2 == 0, 32'($urandom_range(0, 255)) << 4, $urandom % 2 == 0,
           $urandom % 3 != 0, $urandom % 40 == 0, $urandom % 150 != 0, "rnd");
    end
    act_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
